// File: rtl/imm_decode_stage_pkg.sv
// Shared decode constants: instruction formats, extend-unit select codes and
// field bit positions. The extend unit imports these same definitions.
package imm_decode_stage_pkg;

  typedef enum logic [1:0] {
    FMT_REG   = 2'b00,
    FMT_ADDR  = 2'b01,
    FMT_IMM19 = 2'b10,
    FMT_IMM15 = 2'b11
  } fmt_e;

  localparam logic [1:0] EXT_SEL_REG   = 2'b00;
  localparam logic [1:0] EXT_SEL_ADDR  = 2'b01;
  localparam logic [1:0] EXT_SEL_IMM19 = 2'b10;
  localparam logic [1:0] EXT_SEL_IMM15 = 2'b11;

  localparam int FMT_HI = 31;
  localparam int FMT_LO = 30;
  localparam int OP_HI  = 29;
  localparam int OP_LO  = 23;
  localparam int INM_HI = 22;
  localparam int INM_LO = 0;
  localparam int INM_W  = INM_HI - INM_LO + 1;
  localparam int OP_W   = OP_HI - OP_LO + 1;

  typedef struct packed {
    logic [INM_W-1:0] inm;
    logic [1:0]       sel;
    logic [OP_W-1:0]  op;
  } dec_t;

endpackage

// File: rtl/imm_decode_stage_if.sv
// Stage bus: upstream valid/ready, downstream valid/ready with decoded fields.
interface imm_decode_stage_if #(parameter int CNT_W = 16);
  logic             flush;
  logic             in_valid;
  logic [31:0]      in_instr;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [22:0]      out_inm;
  logic [1:0]       out_extendSel;
  logic [6:0]       out_op;
  logic [CNT_W-1:0] out_count;

  modport master (
    output flush, in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_inm, out_extendSel, out_op, out_count
  );

  modport slave (
    input  flush, in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_inm, out_extendSel, out_op, out_count
  );
endinterface

// File: rtl/imm_decode_stage_field_decode.sv
// Combinational instruction -> {immediate, extend select, opcode} decode.
module imm_field_decode
  import imm_decode_stage_pkg::*;
(
  input  logic [31:0] i_instr,
  output dec_t        o_dec
);

  // Select the extend mode from the format bits; register format carries no immediate.
  always_comb begin
    o_dec     = '0;
    o_dec.op  = i_instr[OP_HI:OP_LO];
    o_dec.inm = i_instr[INM_HI:INM_LO];
    case (fmt_e'(i_instr[FMT_HI:FMT_LO]))
      FMT_REG: begin
        o_dec.sel = EXT_SEL_REG;
        o_dec.inm = '0;
      end
      FMT_ADDR:  o_dec.sel = EXT_SEL_ADDR;
      FMT_IMM19: o_dec.sel = EXT_SEL_IMM19;
      FMT_IMM15: o_dec.sel = EXT_SEL_IMM15;
      default:   o_dec.sel = EXT_SEL_REG;
    endcase
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Decode stage: one output register plus one skid register so in_ready can be
// a flop while still sustaining one word per cycle.
module imm_decode_stage
  import imm_decode_stage_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  imm_decode_stage_if.slave  bus
);

  dec_t             w_dec;
  dec_t             r_out;
  dec_t             r_skid;
  logic             r_out_vld;
  logic             r_skid_vld;
  logic             r_in_rdy;
  logic [CNT_W-1:0] r_count;
  logic             w_acc;
  logic             w_otx;
  logic             w_free;

  imm_field_decode u_dec (
    .i_instr (bus.in_instr),
    .o_dec   (w_dec)
  );

  assign w_acc  = bus.in_valid & r_in_rdy;
  assign w_otx  = r_out_vld & bus.out_ready;
  assign w_free = ~r_out_vld | bus.out_ready;

  // Output/skid occupancy, registered in_ready and the delivered-word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out      <= '0;
      r_skid     <= '0;
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
      r_in_rdy   <= 1'b0;
      r_count    <= '0;
    end else begin
      if (w_otx) r_count <= r_count + 1'b1;
      if (bus.flush) begin
        r_out_vld  <= 1'b0;
        r_skid_vld <= 1'b0;
        r_in_rdy   <= 1'b1;
      end else if (w_free) begin
        // Output slot frees: skid drains first (in_ready was low, so no accept).
        if (r_skid_vld) begin
          r_out      <= r_skid;
          r_out_vld  <= 1'b1;
          r_skid_vld <= 1'b0;
        end else begin
          r_out_vld <= w_acc;
          if (w_acc) r_out <= w_dec;
        end
        r_in_rdy <= 1'b1;
      end else if (w_acc) begin
        r_skid     <= w_dec;
        r_skid_vld <= 1'b1;
        r_in_rdy   <= 1'b0;
      end else begin
        r_in_rdy <= ~r_skid_vld;
      end
    end
  end

  assign bus.in_ready      = r_in_rdy;
  assign bus.out_valid     = r_out_vld;
  assign bus.out_inm       = r_out.inm;
  assign bus.out_extendSel = r_out.sel;
  assign bus.out_op        = r_out.op;
  assign bus.out_count     = r_count;

endmodule
